alu_cmd_sequencer: RTL

Upstream issue stage for the 8-bit combinational `alu`. It accepts commands through a valid/ready port and buffers them in a 4-entry FIFO. For each command it reads two operands from a small register file and drives `A`, `B` and `ALUControl` from registers. On the following cycle it captures `Result` back into the register file and reports the write-back.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 28 ++
 rtl/alu_cmd_fifo.sv | 51 +++++
 rtl/alu_cmd_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, sequencer FSM states and the queued command format for the
// alu issue stage.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;
  localparam logic [2:0] ALU_SHR  = 3'b110;
  localparam logic [2:0] ALU_ZERO = 3'b111;

  localparam int CMD_DATA_W = 8;
  localparam int CMD_REG_AW = 2;

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  typedef struct packed {
    logic                  ld;
    logic [2:0]            op;
    logic [CMD_REG_AW-1:0] rd;
    logic [CMD_REG_AW-1:0] rs1;
    logic [CMD_REG_AW-1:0] rs2;
    logic [CMD_DATA_W-1:0] imm;
  } cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-function ALU fed by the sequencer; results wrap modulo 2^DATA_W.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] Result
);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD:  Result = A + B;
      ALU_SUB:  Result = A - B;
      ALU_AND:  Result = A & B;
      ALU_OR:   Result = A | B;
      ALU_XOR:  Result = A ^ B;
      ALU_SHL:  Result = A << B;
      ALU_SHR:  Result = A >> B;
      ALU_ZERO: Result = '0;
      default:  Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_fifo.sv
// Show-ahead synchronous FIFO; pushes are refused while full, even alongside a pop.
module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic                             pop,
  input  logic [W-1:0]                     din,
  output logic [W-1:0]                     dout,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational alu: queues commands, registers operands
// for one full cycle, then writes the result back into the register file.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W     = CMD_DATA_W,
  parameter int NREGS      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int REG_AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ld,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  state_t                      state, state_n;
  cmd_t                        cmd_in, head;
  logic                        full, empty, pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [DATA_W-1:0]           rf [NREGS];
  logic                        cur_ld;
  logic [REG_AW-1:0]           cur_rd;
  logic [DATA_W-1:0]           cur_imm;
  logic [DATA_W-1:0]           wdata;

  assign cmd_in   = '{ld: in_ld, op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
  assign in_ready = !full;
  assign busy     = (state != IDLE) || (fifo_count != '0);

  alu_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    wdata   = cur_ld ? cur_imm : alu_result;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_n = EXEC;
      end
      EXEC: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pop (IDLE) and write-back (EXEC) never coincide, so operand reads always
  // see the previous command's write without forwarding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rf       <= '{default: '0};
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
      cur_ld   <= 1'b0;
      cur_rd   <= '0;
      cur_imm  <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      state    <= state_n;
      wb_valid <= 1'b0;
      if (pop) begin
        cur_ld  <= head.ld;
        cur_rd  <= head.rd;
        cur_imm <= head.imm;
        if (!head.ld) begin
          alu_a    <= rf[head.rs1];
          alu_b    <= rf[head.rs2];
          alu_ctrl <= head.op;
        end
      end
      if (state == EXEC) begin
        rf[cur_rd] <= wdata;
        wb_valid   <= 1'b1;
        wb_rd      <= cur_rd;
        wb_data    <= wdata;
      end
    end
  end

endmodule
